// File: rtl/sipo_shift_rx.sv
// sipo_shift_rx: serial-in/parallel-out receiver for the PISOshift link.
// Collects WIDTH enabled bits into a shift register, then hands the word
// to a holding register guarded by a valid/ack handshake. If a new word
// completes while the held word is still unacknowledged, the new word is
// dropped and a sticky overrun flag is raised.

module sipo_shift_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sen,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [WIDTH-1:0] word_in;
  logic [WIDTH-1:0] out_next;
  logic             out_valid_next;
  logic             overrun_next;
  logic             complete;

  // State, bit counter, shift register and holding register; rst wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      shreg     <= shreg_next;
      out       <= out_next;
      out_valid <= out_valid_next;
      overrun   <= overrun_next;
    end
  end

  // Frame sequencing plus the holding-register handshake (completion, ack, overrun)
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    shreg_next     = shreg;
    out_next       = out;
    out_valid_next = out_valid;
    overrun_next   = overrun;
    complete       = 1'b0;
    word_in        = MSB_FIRST ? {shreg[WIDTH-2:0], sin} : {sin, shreg[WIDTH-1:1]};

    case (state)
      IDLE: begin
        if (sen) begin
          shreg_next = word_in;
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (sen) begin
          shreg_next = word_in;
          if (cnt == LAST) begin
            cnt_next   = '0;
            state_next = IDLE;
            complete   = 1'b1;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (complete) begin
      if (!out_valid || out_ack) begin
        out_next       = word_in;
        out_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (out_valid && out_ack) begin
      out_valid_next = 1'b0;
    end
  end

  // A frame is in progress exactly while the FSM sits in SHIFT
  always_comb begin
    busy = (state == SHIFT);
  end

endmodule
